// File: rtl/lx_bus_arbiter_pkg.sv
// Shared types for the lowX arbiter: cache-side and memory-side line request/response
// structs, arbiter FSM states and grant sources.
package lx_bus_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BLK_SIZE = 128;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] addr;
    logic            uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } ilowX_res_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic                rw;
    logic [1:0]          rw_type;
    logic                uncached;
    logic [BLK_SIZE-1:0] data;
  } dlowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic                rw;
    logic [1:0]          rw_type;
    logic                uncached;
    logic [BLK_SIZE-1:0] data;
  } lowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowX_res_t;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} arb_state_e;

  typedef enum logic {ARB_ICACHE, ARB_DCACHE} arb_src_e;

  // Icache fetches are always line reads; write-side fields are forced to zero.
  function automatic lowX_req_t icache_to_lx(input ilowX_req_t r);
    lowX_req_t o;
    o          = '0;
    o.valid    = 1'b1;
    o.addr     = r.addr;
    o.uncached = r.uncached;
    return o;
  endfunction

  function automatic lowX_req_t dcache_to_lx(input dlowX_req_t r);
    lowX_req_t o;
    o          = '0;
    o.valid    = 1'b1;
    o.addr     = r.addr;
    o.rw       = r.rw;
    o.rw_type  = r.rw_type;
    o.uncached = r.uncached;
    o.data     = r.data;
    return o;
  endfunction

endpackage

// File: rtl/lx_bus_arbiter.sv
// Round-robin arbiter sharing the lowX memory port between icache and dcache; one registered
// line transaction at a time, response routed back only to the granted cache.
module lx_bus_arbiter
  import lx_bus_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  ilowX_req_t icache_req_i,
  output ilowX_res_t icache_res_o,
  input  dlowX_req_t dcache_req_i,
  output dlowX_res_t dcache_res_o,
  output lowX_req_t  lx_req_o,
  input  lowX_res_t  lx_res_i,
  output logic       busy_o
);

  arb_state_e r_state;
  arb_src_e   r_last;
  lowX_req_t  r_req;
  logic       r_busy;
  logic       r_rdy;

  logic w_pick_i;
  logic w_pick_d;
  logic w_resp_i;
  logic w_resp_d;
  logic w_unused;

  // On a tie the cache that did not win last time gets the port.
  assign w_pick_d = dcache_req_i.valid & (~icache_req_i.valid | (r_last == ARB_ICACHE));
  assign w_pick_i = icache_req_i.valid & ~w_pick_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_last  <= ARB_ICACHE;
      r_req   <= '0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state <= GNT_D;
            r_last  <= ARB_DCACHE;
            r_req   <= dcache_to_lx(dcache_req_i);
            r_busy  <= 1'b1;
          end else if (w_pick_i) begin
            r_state <= GNT_I;
            r_last  <= ARB_ICACHE;
            r_req   <= icache_to_lx(icache_req_i);
            r_busy  <= 1'b1;
          end
        end
        GNT_I, GNT_D: begin
          if (lx_res_i.valid) begin
            r_state     <= DONE;
            r_req.valid <= 1'b0;
          end
        end
        DONE: begin
          // Dead cycle so the served requester can drop valid before re-arbitration.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_resp_i = (r_state == GNT_I) & lx_res_i.valid;
  assign w_resp_d = (r_state == GNT_D) & lx_res_i.valid;

  always_comb begin
    icache_res_o       = '0;
    icache_res_o.valid = w_resp_i;
    icache_res_o.ready = 1'b1;
    icache_res_o.data  = w_resp_i ? lx_res_i.data : '0;

    dcache_res_o       = '0;
    dcache_res_o.valid = w_resp_d;
    dcache_res_o.ready = 1'b1;
    dcache_res_o.data  = w_resp_d ? lx_res_i.data : '0;

    lx_req_o       = r_req;
    lx_req_o.ready = r_rdy;
  end

  assign busy_o = r_busy;

  assign w_unused = ^{icache_req_i.ready, dcache_req_i.ready, lx_res_i.ready, r_req.ready};

endmodule

// File: tb/tb_lx_bus_arbiter.sv
// Bench for lx_bus_arbiter: transaction table, directed multi-cycle corner cases and a
// randomized run against a transaction-level model of the arbitration rules.
module tb_lx_bus_arbiter;
  import lx_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  ilowX_req_t icache_req_i;
  ilowX_res_t icache_res_o;
  dlowX_req_t dcache_req_i;
  dlowX_res_t dcache_res_o;
  lowX_req_t  lx_req_o;
  lowX_res_t  lx_res_i;
  logic       busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lx_bus_arbiter u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .icache_req_i (icache_req_i),
    .icache_res_o (icache_res_o),
    .dcache_req_i (dcache_req_i),
    .dcache_res_o (dcache_res_o),
    .lx_req_o     (lx_req_o),
    .lx_res_i     (lx_res_i),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [1:0]   who;     // bit0 icache valid, bit1 dcache valid
    logic [31:0]  i_addr;
    logic         i_unc;
    logic [31:0]  d_addr;
    logic         d_rw;
    logic [1:0]   d_rwt;
    logic         d_unc;
    logic [127:0] d_data;
    int           lat;
    logic [127:0] rdata;
    logic         exp_d;   // 1: dcache expected to win
    logic [31:0]  e_addr;
    logic         e_rw;
    logic [1:0]   e_rwt;
    logic         e_unc;
    logic [127:0] e_data;
  } vec_t;

  vec_t tv[6];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] flds(input lowX_req_t r);
    return 256'({r.addr, r.rw, r.rw_type, r.uncached, r.data});
  endfunction

  function automatic logic [255:0] flds_exp(input logic [31:0] a, input logic rw,
                                            input logic [1:0] t, input logic u,
                                            input logic [127:0] d);
    return 256'({a, rw, t, u, d});
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    icache_req_i = '0;
    dcache_req_i = '0;
    lx_res_i     = '0;
    @(negedge clk);
    chkw("rst_lx_req", 256'(lx_req_o), 256'(0));
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_ires_valid", icache_res_o.valid, 1'b0);
    chk1("rst_dres_valid", dcache_res_o.valid, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!lx_req_o.valid && n < 8) begin
      step();
      n++;
    end
    chk1(nm, lx_req_o.valid, 1'b1);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int n;
    logic [255:0] e_f;
    e_f = flds_exp(v.e_addr, v.e_rw, v.e_rwt, v.e_unc, v.e_data);
    step();
    icache_req_i = '{valid: v.who[0], ready: 1'b1, addr: v.i_addr, uncached: v.i_unc};
    dcache_req_i = '{valid: v.who[1], ready: 1'b1, addr: v.d_addr, rw: v.d_rw,
                     rw_type: v.d_rwt, uncached: v.d_unc, data: v.d_data};
    lx_res_i = '0;
    @(negedge clk);
    chk1($sformatf("v%0d_busy_grant", idx), busy_o, 1'b0);
    chk1($sformatf("v%0d_lxv_grant", idx), lx_req_o.valid, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (!lx_req_o.valid && n < 8);
    chkw($sformatf("v%0d_req_latency", idx), 256'(n), 256'(1));
    chkw($sformatf("v%0d_lx_fields", idx), flds(lx_req_o), e_f);
    chk1($sformatf("v%0d_lx_ready", idx), lx_req_o.ready, 1'b1);
    // Requesters scribble over their inputs; the captured request must not follow.
    icache_req_i.addr = 32'hDEAD_BEEF;
    dcache_req_i.addr = 32'hDEAD_BEEF;
    dcache_req_i.data = '1;
    for (int k = 0; k < v.lat; k++) begin
      @(negedge clk);
      chk1($sformatf("v%0d_ires_early", idx), icache_res_o.valid, 1'b0);
      chk1($sformatf("v%0d_dres_early", idx), dcache_res_o.valid, 1'b0);
      step();
      chkw($sformatf("v%0d_lx_hold", idx), flds(lx_req_o), e_f);
    end
    lx_res_i = '{valid: 1'b1, ready: 1'b0, data: v.rdata};
    @(negedge clk);
    chkw($sformatf("v%0d_lx_hold_resp", idx), flds(lx_req_o), e_f);
    chk1($sformatf("v%0d_ires_valid", idx), icache_res_o.valid, !v.exp_d);
    chk1($sformatf("v%0d_dres_valid", idx), dcache_res_o.valid, v.exp_d);
    chkw($sformatf("v%0d_res_data", idx),
         256'(v.exp_d ? dcache_res_o.data : icache_res_o.data), 256'(v.rdata));
    step();
    lx_res_i           = '0;
    icache_req_i.valid = 1'b0;
    dcache_req_i.valid = 1'b0;
    @(negedge clk);
    chk1($sformatf("v%0d_done_lxv", idx), lx_req_o.valid, 1'b0);
    chk1($sformatf("v%0d_done_busy", idx), busy_o, 1'b1);
    chk1($sformatf("v%0d_done_ires", idx), icache_res_o.valid, 1'b0);
    chk1($sformatf("v%0d_done_dres", idx), dcache_res_o.valid, 1'b0);
    step();
    @(negedge clk);
    chk1($sformatf("v%0d_idle_busy", idx), busy_o, 1'b0);
  endtask

  // Random-phase model state.
  bit           in_txn;
  bit           t_d;
  bit           m_last_d;
  bit           drop_i;
  bit           drop_d;
  bit           mem_armed;
  bit           e_lxv;
  bit           e_iv;
  bit           e_dv;
  int           g_cyc;
  int           done_cyc;
  int           mem_cnt;
  logic [255:0] e_f_rnd;

  initial begin
    tv[0] = '{2'b01, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 128'h0,
              3, 128'h0123456789ABCDEF0123456789ABCDEF,
              1'b0, 32'h8000_0040, 1'b0, 2'b00, 1'b0, 128'h0};
    tv[1] = '{2'b10, 32'h0, 1'b0, 32'h8000_1000, 1'b1, 2'b10, 1'b1,
              128'hAAAAAAAA_AAAAAAAA_55555555_55555555,
              1, 128'h0,
              1'b1, 32'h8000_1000, 1'b1, 2'b10, 1'b1, 128'hAAAAAAAA_AAAAAAAA_55555555_55555555};
    tv[2] = '{2'b10, 32'h0, 1'b0, 32'h8000_2000, 1'b0, 2'b01, 1'b0, 128'h1111_2222,
              0, 128'hFEDCBA98_76543210_FEDCBA98_76543210,
              1'b1, 32'h8000_2000, 1'b0, 2'b01, 1'b0, 128'h1111_2222};
    tv[3] = '{2'b01, 32'h0000_0FFC, 1'b1, 32'h0, 1'b0, 2'b00, 1'b0, 128'h0,
              5, 128'h0F0F0F0F_00000000_FFFFFFFF_12345678,
              1'b0, 32'h0000_0FFC, 1'b0, 2'b00, 1'b1, 128'h0};
    // Ties: previous winner was icache, so dcache first, then icache.
    tv[4] = '{2'b11, 32'h1000_0000, 1'b0, 32'h2000_0000, 1'b1, 2'b11, 1'b0,
              128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D,
              2, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A,
              1'b1, 32'h2000_0000, 1'b1, 2'b11, 1'b0, 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D};
    tv[5] = '{2'b11, 32'h1000_0040, 1'b1, 32'h2000_0040, 1'b1, 2'b01, 1'b1,
              128'hBEEF, 1, 128'h7777,
              1'b0, 32'h1000_0040, 1'b0, 2'b00, 1'b1, 128'h0};

    do_reset();
    for (int i = 0; i < 6; i++) run_txn(tv[i], i);

    // Stray memory response while idle is ignored.
    step();
    lx_res_i = '{valid: 1'b1, ready: 1'b1, data: '1};
    @(negedge clk);
    chk1("stray_ires", icache_res_o.valid, 1'b0);
    chk1("stray_dres", dcache_res_o.valid, 1'b0);
    chk1("stray_busy", busy_o, 1'b0);
    step();
    lx_res_i = '0;
    @(negedge clk);
    chk1("stray_busy_after", busy_o, 1'b0);
    chk1("stray_lxv_after", lx_req_o.valid, 1'b0);

    // Asynchronous reset in the middle of an icache grant.
    step();
    icache_req_i = '{valid: 1'b1, ready: 1'b1, addr: 32'h8000_0080, uncached: 1'b0};
    wait_req("arst_pre_grant");
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk1("arst_lxv", lx_req_o.valid, 1'b0);
    chk1("arst_busy", busy_o, 1'b0);
    chkw("arst_lx_req", 256'(lx_req_o), 256'(0));
    icache_req_i = '0;
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
    run_txn(tv[0], 10);

    // Tie right after reset: dcache, then the still-pending icache, then dcache again.
    do_reset();
    step();
    icache_req_i = '{valid: 1'b1, ready: 1'b1, addr: 32'h1111_1100, uncached: 1'b0};
    dcache_req_i = '{valid: 1'b1, ready: 1'b1, addr: 32'h2222_2200, rw: 1'b0,
                     rw_type: 2'b00, uncached: 1'b0, data: '0};
    step();
    wait_req("tie1_grant");
    chkw("tie1_addr", 256'(lx_req_o.addr), 256'(32'h2222_2200));
    lx_res_i = '{valid: 1'b1, ready: 1'b1, data: 128'h1};
    @(negedge clk);
    chk1("tie1_dres", dcache_res_o.valid, 1'b1);
    chk1("tie1_ires", icache_res_o.valid, 1'b0);
    step();
    lx_res_i           = '0;
    dcache_req_i.valid = 1'b0;
    @(negedge clk);
    chk1("tie1_done_lxv", lx_req_o.valid, 1'b0);
    step();
    @(negedge clk);
    chk1("tie2_grant_lxv", lx_req_o.valid, 1'b0);
    step();
    chk1("tie2_lxv", lx_req_o.valid, 1'b1);
    chkw("tie2_addr", 256'(lx_req_o.addr), 256'(32'h1111_1100));
    lx_res_i = '{valid: 1'b1, ready: 1'b1, data: 128'h2};
    @(negedge clk);
    chk1("tie2_ires", icache_res_o.valid, 1'b1);
    chk1("tie2_dres", dcache_res_o.valid, 1'b0);
    step();
    lx_res_i     = '0;
    // New requests raised during the dead cycle: no grant yet, tie decided next cycle.
    icache_req_i = '{valid: 1'b1, ready: 1'b1, addr: 32'h3333_3300, uncached: 1'b0};
    dcache_req_i = '{valid: 1'b1, ready: 1'b1, addr: 32'h4444_4400, rw: 1'b0,
                     rw_type: 2'b00, uncached: 1'b0, data: '0};
    @(negedge clk);
    chk1("tie3_done_lxv", lx_req_o.valid, 1'b0);
    step();
    step();
    chk1("tie3_lxv", lx_req_o.valid, 1'b1);
    chkw("tie3_addr", 256'(lx_req_o.addr), 256'(32'h4444_4400));
    lx_res_i = '{valid: 1'b1, ready: 1'b1, data: 128'h3};
    @(negedge clk);
    chk1("tie3_dres", dcache_res_o.valid, 1'b1);
    step();
    lx_res_i     = '0;
    icache_req_i = '0;
    dcache_req_i = '0;
    repeat (3) step();

    // Randomized traffic against the transaction-level model.
    do_reset();
    in_txn    = 1'b0;
    done_cyc  = -10;
    g_cyc     = 0;
    m_last_d  = 1'b0;
    t_d       = 1'b0;
    drop_i    = 1'b0;
    drop_d    = 1'b0;
    mem_armed = 1'b0;
    mem_cnt   = 0;
    e_f_rnd   = '0;
    for (int k = 0; k < 3000; k++) begin
      step();
      lx_res_i       = '0;
      lx_res_i.ready = 1'($urandom_range(0, 1));
      if (lx_req_o.valid) begin
        if (!mem_armed) begin
          mem_armed = 1'b1;
          mem_cnt   = $urandom_range(0, 4);
        end
        if (mem_cnt == 0) begin
          lx_res_i.valid = 1'b1;
          lx_res_i.data  = rnd128();
          mem_armed      = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else begin
        mem_armed = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          lx_res_i.valid = 1'b1;
          lx_res_i.data  = rnd128();
        end
      end

      if (drop_i) begin
        icache_req_i.valid = 1'b0;
        drop_i             = 1'b0;
      end else if (!icache_req_i.valid) begin
        if (!(in_txn && !t_d) && $urandom_range(0, 2) == 0)
          icache_req_i = '{valid: 1'b1, ready: 1'($urandom_range(0, 1)), addr: $urandom,
                           uncached: 1'($urandom_range(0, 1))};
      end else begin
        if ($urandom_range(0, 3) == 0) icache_req_i.addr = $urandom;
        if (in_txn && !t_d && $urandom_range(0, 7) == 0) icache_req_i.valid = 1'b0;
      end

      if (drop_d) begin
        dcache_req_i.valid = 1'b0;
        drop_d             = 1'b0;
      end else if (!dcache_req_i.valid) begin
        if (!(in_txn && t_d) && $urandom_range(0, 2) == 0)
          dcache_req_i = '{valid: 1'b1, ready: 1'($urandom_range(0, 1)), addr: $urandom,
                           rw: 1'($urandom_range(0, 1)), rw_type: 2'($urandom_range(0, 3)),
                           uncached: 1'($urandom_range(0, 1)), data: rnd128()};
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          dcache_req_i.addr = $urandom;
          dcache_req_i.data = rnd128();
        end
        if (in_txn && t_d && $urandom_range(0, 7) == 0) dcache_req_i.valid = 1'b0;
      end

      @(negedge clk);
      e_lxv = in_txn && (k > g_cyc);
      e_iv  = e_lxv && !t_d && lx_res_i.valid;
      e_dv  = e_lxv && t_d && lx_res_i.valid;
      chk1("rnd_busy", busy_o, e_lxv || (k == done_cyc));
      chk1("rnd_lx_valid", lx_req_o.valid, e_lxv);
      chk1("rnd_ires_valid", icache_res_o.valid, e_iv);
      chk1("rnd_dres_valid", dcache_res_o.valid, e_dv);
      if (e_lxv) chkw("rnd_lx_fields", flds(lx_req_o), e_f_rnd);
      if (e_iv) chkw("rnd_ires_data", 256'(icache_res_o.data), 256'(lx_res_i.data));
      if (e_dv) chkw("rnd_dres_data", 256'(dcache_res_o.data), 256'(lx_res_i.data));
      if (e_iv || e_dv) begin
        in_txn   = 1'b0;
        done_cyc = k + 1;
        if (t_d) drop_d = 1'b1;
        else     drop_i = 1'b1;
      end else if (!in_txn && k != done_cyc && (icache_req_i.valid || dcache_req_i.valid)) begin
        t_d      = dcache_req_i.valid && (!icache_req_i.valid || !m_last_d);
        m_last_d = t_d;
        in_txn   = 1'b1;
        g_cyc    = k;
        e_f_rnd  = t_d ? flds_exp(dcache_req_i.addr, dcache_req_i.rw, dcache_req_i.rw_type,
                                  dcache_req_i.uncached, dcache_req_i.data)
                       : flds_exp(icache_req_i.addr, 1'b0, 2'b00, icache_req_i.uncached,
                                  128'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
